edsac_mcu_stage: RTL

EDSAC_MCU_STAGE -- requirements
Module: edsac_mcu_stage

---
 rtl/edsac_mcu_stage_pkg.sv | 14 +
 rtl/edsac_mcu_stage.sv | 117 +++++++++++
 2 files changed

// File: rtl/edsac_mcu_stage_pkg.sv
// Shared control-section definitions: main-control state encoding and the
// sequence control tank width.
package edsac_mcu_stage_pkg;

   localparam int SCT_W = 10;

   typedef enum logic [1:0] {
      ST_STOPPED = 2'd0,
      ST_S1_REQ  = 2'd1,
      ST_S1_INC  = 2'd2,
      ST_S2_EXEC = 2'd3
   } mcu_state_e;

endpackage

// File: rtl/edsac_mcu_stage.sv
// Main control stage sequencer: alternates order fetch (stage 1) and order
// execution (stage 2) on minor-cycle boundaries, and owns the SCT.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// STOPPED    | idle; waits for the run button
// S1_REQ     | stage 1: order requested from store, waiting for order_ack
// S1_INC     | stage 1: advance sct to the next order address
// S2_EXEC    | stage 2: order executing, waiting for the end pulse
module edsac_mcu_stage
   import edsac_mcu_stage_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mc_tick,
   input  logic             start,
   input  logic             stop_req,
   input  logic             single_step,
   input  logic             order_ack,
   input  logic             ep,
   input  logic             jump,
   input  logic [SCT_W-1:0] jump_addr,
   output logic             running,
   output logic             stage1,
   output logic             stage2,
   output logic             order_req,
   output logic [SCT_W-1:0] sct,
   output logic             err_ep
);

   mcu_state_e       state_q, state_d;
   logic [SCT_W-1:0] sct_d;
   logic             ack_p_q, ack_p_d;
   logic             ep_p_q, ep_p_d;
   logic             jmp_p_q, jmp_p_d;
   logic [SCT_W-1:0] jaddr_p_q, jaddr_p_d;
   logic             err_d;
   logic             jmp_use;
   logic [SCT_W-1:0] jaddr_use;

   // A live end pulse on the exit tick overrides whatever was captured.
   assign jmp_use   = ep ? jump      : jmp_p_q;
   assign jaddr_use = ep ? jump_addr : jaddr_p_q;

   always_comb begin
      state_d   = state_q;
      sct_d     = sct;
      ack_p_d   = ack_p_q;
      ep_p_d    = ep_p_q;
      jmp_p_d   = jmp_p_q;
      jaddr_p_d = jaddr_p_q;
      err_d     = err_ep;

      unique case (state_q)
         ST_STOPPED: begin
            if (start) state_d = ST_S1_REQ;
         end
         ST_S1_REQ: begin
            if (mc_tick && (ack_p_q || order_ack)) begin
               state_d = ST_S1_INC;
               ack_p_d = 1'b0;
            end else if (order_ack) begin
               ack_p_d = 1'b1;
            end
         end
         ST_S1_INC: begin
            if (mc_tick) begin
               sct_d   = sct + SCT_W'(1);
               state_d = ST_S2_EXEC;
            end
         end
         ST_S2_EXEC: begin
            if (mc_tick && (ep_p_q || ep)) begin
               if (jmp_use) sct_d = jaddr_use;
               ep_p_d  = 1'b0;
               jmp_p_d = 1'b0;
               state_d = (stop_req || single_step) ? ST_STOPPED : ST_S1_REQ;
            end else if (ep) begin
               ep_p_d    = 1'b1;
               jmp_p_d   = jump;
               jaddr_p_d = jump_addr;
            end
         end
         default: state_d = ST_STOPPED;
      endcase

      // An out-of-place end pulse is recorded even if start arrives with it.
      if (ep && state_q != ST_S2_EXEC) err_d = 1'b1;
      else if (start)                  err_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_STOPPED;
         sct       <= '0;
         ack_p_q   <= 1'b0;
         ep_p_q    <= 1'b0;
         jmp_p_q   <= 1'b0;
         jaddr_p_q <= '0;
         err_ep    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sct       <= sct_d;
         ack_p_q   <= ack_p_d;
         ep_p_q    <= ep_p_d;
         jmp_p_q   <= jmp_p_d;
         jaddr_p_q <= jaddr_p_d;
         err_ep    <= err_d;
      end
   end

   assign running   = (state_q != ST_STOPPED);
   assign stage1    = (state_q == ST_S1_REQ) || (state_q == ST_S1_INC);
   assign stage2    = (state_q == ST_S2_EXEC);
   assign order_req = (state_q == ST_S1_REQ);

endmodule
